// File: rtl/tabulate_stim_checker_if.sv
// Purpose: one valid/ready stream (valid, ready, bits). The checker drives its
//          stimulus through a master modport and takes the lane's responses
//          through a slave modport.
// Handshake: a beat transfers on every rising clock edge where valid & ready
//          are both high. While valid is high and ready is low, the master
//          keeps valid and bits unchanged.
// Signals: valid (master->slave), bits[W-1:0] (master->slave),
//          ready (slave->master).
interface tabulate_stim_checker_if #(
  parameter int W = 32
);
  logic         valid;
  logic         ready;
  logic [W-1:0] bits;

  modport master (output valid, output bits, input ready);
  modport slave  (input valid, input bits, output ready);
endinterface

// File: rtl/tabulate_stim_checker.sv
// Purpose: stimulus generator and in-order response checker for one lane.
//   The generator walks (i,j,k), with k fastest, and emits i+j+k+1 on src.
//   Every accepted stimulus value is also written into a small expected-value
//   queue. The lane's responses arrive on snk and are compared in order with
//   the head of that queue.
// Ports:
//   i_clock, i_reset : clock and synchronous active-high reset
//   i_start          : start pulse, accepted only in IDLE or DONE
//   src (master)     : stimulus stream to the lane (out_valid/out_ready/out_bits)
//   snk (slave)      : response stream from the lane (in_valid/in_ready/in_bits)
//   o_busy           : high in RUN or DRAIN
//   o_done, o_pass   : registered result; held until the next start or reset
//   o_err_count      : mismatches + unexpected responses + timeouts, saturating
//   o_state          : current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
module tabulate_stim_checker #(
  parameter int W         = 32,
  parameter int DIM0      = 3,
  parameter int DIM1      = 4,
  parameter int DIM2      = 2,
  parameter int EXP_DEPTH = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  tabulate_stim_checker_if.master src,
  tabulate_stim_checker_if.slave  snk,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_pass,
  output logic [15:0]            o_err_count,
  output logic [1:0]             o_state
);
  localparam int IW0 = (DIM0 > 1) ? $clog2(DIM0) : 1;
  localparam int IW1 = (DIM1 > 1) ? $clog2(DIM1) : 1;
  localparam int IW2 = (DIM2 > 1) ? $clog2(DIM2) : 1;
  localparam int AW  = $clog2(EXP_DEPTH);
  localparam int CW  = AW + 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [IW0-1:0]  r_i;
  logic [IW1-1:0]  r_j;
  logic [IW2-1:0]  r_k;
  logic [W-1:0]    r_mem [EXP_DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_count;
  logic [TW-1:0]   r_timer;
  logic [15:0]     r_err;
  logic            r_done;
  logic            r_pass;

  logic            w_run;
  logic            w_busy;
  logic            w_full;
  logic            w_empty;
  logic [31:0]     w_val;
  logic            w_push;
  logic            w_in_fire;
  logic            w_pop;
  logic            w_mismatch;
  logic            w_unexp;
  logic            w_timeout;
  logic            w_last;
  logic [16:0]     w_err_sum;
  logic [15:0]     w_err_next;

  // Every output below is decoded from registers only, so src.valid never
  // depends combinationally on src.ready or on any snk input.
  always_comb begin
    w_run      = (r_state == S_RUN);
    w_busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
    w_full     = (r_count == CW'(EXP_DEPTH));
    w_empty    = (r_count == '0);
    w_val      = 32'(r_i) + 32'(r_j) + 32'(r_k) + 32'd1;
    src.valid  = w_run & ~w_full;
    src.bits   = w_run ? W'(w_val) : '0;
    snk.ready  = w_busy;
    w_push     = src.valid & src.ready;
    w_in_fire  = snk.valid & w_busy;
    w_pop      = w_in_fire & ~w_empty;
    w_mismatch = w_pop & (r_mem[r_rd] != snk.bits);
    w_unexp    = w_in_fire & w_empty;
    // The timer only advances on cycles with no response, so a timeout can
    // never coincide with a compare in the same cycle.
    w_timeout  = (r_state == S_DRAIN) & ~w_empty & ~w_in_fire &
                 (r_timer == TW'(TIMEOUT - 1));
    w_last     = w_push & (r_i == IW0'(DIM0 - 1)) & (r_j == IW1'(DIM1 - 1)) &
                 (r_k == IW2'(DIM2 - 1));
    w_err_sum  = {1'b0, r_err} + 17'(w_mismatch) + 17'(w_unexp) + 17'(w_timeout);
    w_err_next = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_timer <= '0;
      r_err   <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_err <= w_err_next;

      // Expected-value queue. When a push and a pop happen together, the
      // occupancy is unchanged, which lets a full queue still drain.
      if (w_push) begin
        r_mem[r_wr] <= src.bits;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);

      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state <= S_RUN;
            r_err   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_timer <= '0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        S_RUN: begin
          // Advance k, then j, then i. After the last element all three
          // indices wrap to zero.
          if (w_push) begin
            if (r_k == IW2'(DIM2 - 1)) begin
              r_k <= '0;
              if (r_j == IW1'(DIM1 - 1)) begin
                r_j <= '0;
                if (r_i == IW0'(DIM0 - 1)) r_i <= '0;
                else                       r_i <= r_i + 1'b1;
              end else begin
                r_j <= r_j + 1'b1;
              end
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
          if (w_last) begin
            r_state <= S_DRAIN;
            r_timer <= '0;
          end
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else if (w_in_fire) begin
            r_timer <= '0;
          end else if (w_timeout) begin
            // Give up on the missing responses. Flush the queue so the next
            // run starts clean.
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_pass  <= 1'b0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = w_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_err_count = r_err;
  assign o_state     = r_state;
endmodule

// File: tb/tb_tabulate_stim_checker.sv
module tb_tabulate_stim_checker;
  localparam int W      = 32;
  localparam int DIM0   = 3;
  localparam int DIM1   = 4;
  localparam int DIM2   = 2;
  localparam int N_ELEM = DIM0 * DIM1 * DIM2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  tabulate_stim_checker_if #(.W(W)) src_if ();
  tabulate_stim_checker_if #(.W(W)) snk_if ();

  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [1:0]  state;

  tabulate_stim_checker #(.W(W)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_start     (start),
    .src         (src_if),
    .snk         (snk_if),
    .o_busy      (busy),
    .o_done      (done),
    .o_pass      (pass),
    .o_err_count (err_count),
    .o_state     (state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // lane model configuration
  int cfg_delay = 1;
  int cfg_ready = 100;
  int cfg_corrupt_idx = 0;
  bit cfg_drop = 1'b0;
  bit cfg_inject = 1'b0;
  bit inject_done = 1'b0;
  bit idle_junk = 1'b0;
  int fire_cnt = 0;
  int outstanding = 0;
  int cyc = 0;
  logic [W-1:0] lane_v[$];
  int           lane_t[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference sequence: every (i,j,k) with k fastest, value i+j+k+1.
  task automatic load_expected();
    exp_q.delete();
    for (int i = 0; i < DIM0; i++)
      for (int j = 0; j < DIM1; j++)
        for (int k = 0; k < DIM2; k++)
          exp_q.push_back(W'(i + j + k + 1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(src_if.valid), 32'd0);
    check({tag, "_out_bits"},  src_if.bits,       32'd0);
    check({tag, "_in_ready"},  32'(snk_if.ready), 32'd0);
    check({tag, "_busy"},      32'(busy),         32'd0);
    check({tag, "_done"},      32'(done),         32'd0);
    check({tag, "_pass"},      32'(pass),         32'd0);
    check({tag, "_err"},       32'(err_count),    32'd0);
    check({tag, "_state"},     32'(state),        32'd0);
  endtask

  // ---------------- lane model / driver ----------------
  // Delay line with latency cfg_delay (>=1) and optional faults. All inputs
  // change on the falling edge.
  initial begin
    logic [W-1:0] v;
    src_if.ready = 1'b0;
    snk_if.valid = 1'b0;
    snk_if.bits  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      src_if.ready = ($urandom_range(0, 99) < cfg_ready);
      if (!busy) begin
        lane_v.delete();
        lane_t.delete();
        outstanding  = 0;
        snk_if.valid = idle_junk;
        snk_if.bits  = W'($urandom);
      end else if (cfg_inject && !inject_done && outstanding == 0) begin
        snk_if.valid = 1'b1;
        snk_if.bits  = W'(32'hDEADBEEF);
        inject_done  = 1'b1;
      end else if (lane_v.size() > 0 && lane_t[0] <= cyc) begin
        snk_if.valid = 1'b1;
        snk_if.bits  = lane_v.pop_front();
        void'(lane_t.pop_front());
        outstanding--;
      end else begin
        snk_if.valid = 1'b0;
        snk_if.bits  = '0;
      end
      if (src_if.valid && src_if.ready) begin
        fire_cnt++;
        outstanding++;
        v = src_if.bits;
        if (fire_cnt == cfg_corrupt_idx) v = v + 1'b1;
        if (!(cfg_drop && fire_cnt == N_ELEM)) begin
          lane_v.push_back(v);
          lane_t.push_back(cyc + cfg_delay);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && src_if.valid && src_if.ready) begin
        if (exp_q.size() == 0) begin
          check("stim_extra", src_if.bits, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("stim_value", src_if.bits, e);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic run_scenario(input int dly, input int rdy, input int corrupt_idx,
                              input bit drop, input bit inject, input bit mid_start);
    int  exp_errs;
    bit  got_done;
    cfg_delay       = dly;
    cfg_ready       = rdy;
    cfg_corrupt_idx = corrupt_idx;
    cfg_drop        = drop;
    cfg_inject      = inject;
    inject_done     = 1'b0;
    fire_cnt        = 0;
    exp_errs = ((corrupt_idx > 0) ? 1 : 0) + (drop ? 1 : 0) + (inject ? 1 : 0);
    load_expected();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #2;
      if (mid_start && c == 20) start = 1'b1;
      if (mid_start && c == 21) start = 1'b0;
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("done_reached", 32'(got_done), 32'd1);
    check("err_count",    32'(err_count), 32'(exp_errs));
    check("pass",         32'(pass), (exp_errs == 0) ? 32'd1 : 32'd0);
    check("all_emitted",  32'(exp_q.size()), 32'd0);
    check("fire_count",   32'(fire_cnt), 32'(N_ELEM));
    check("done_busy",    32'(busy), 32'd0);
    check("done_in_ready", 32'(snk_if.ready), 32'd0);
    check("done_out_valid", 32'(src_if.valid), 32'd0);
    // Responses presented in DONE must be ignored, and done must stay held.
    idle_junk = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    idle_junk = 1'b0;
    check("done_held",       32'(done), 32'd1);
    check("done_err_stable", 32'(err_count), 32'(exp_errs));
  endtask

  task automatic run_reset_case();
    bit hit;
    cfg_delay       = 2;
    cfg_ready       = 100;
    cfg_corrupt_idx = 3;
    cfg_drop        = 1'b0;
    cfg_inject      = 1'b0;
    fire_cnt        = 0;
    load_expected();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      #2;
      if (fire_cnt >= 10) begin
        hit = 1'b1;
        break;
      end
    end
    check("reach_elem10",  32'(hit), 32'd1);
    check("pre_reset_err", 32'(err_count), 32'd1);
    check("pre_reset_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    check_idle_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    run_scenario(4, 60, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("idle_state", 32'(state), 32'd0);

    run_scenario(1, 100, 0, 1'b0, 1'b0, 1'b0);   // wire-like lane, always ready
    run_scenario(3, 50,  0, 1'b0, 1'b0, 1'b1);   // 3-cycle lane, 50% ready, stray start
    run_scenario(2, 70,  5, 1'b0, 1'b0, 1'b0);   // 5th response corrupted
    run_scenario(1, 100, 0, 1'b1, 1'b0, 1'b0);   // last response dropped -> timeout
    run_scenario(2, 80,  0, 1'b0, 1'b1, 1'b0);   // extra response while queue empty
    run_reset_case();
    for (int r = 0; r < 3; r++) begin
      int cidx;
      cidx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, N_ELEM)) : 0;
      run_scenario(int'($urandom_range(1, 6)), int'($urandom_range(30, 100)),
                   cidx, 1'b0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
